// File: rtl/iteration_uart_packer_pkg.sv
// Shared definitions for the iteration UART packer: FSM encoding, payload geometry, sync byte.
// Latency: n/a (types, constants and a pure byte-select function only).
// Backpressure: n/a.
package iteration_uart_packer_pkg;

  localparam int         PAYLOAD_W         = 102;
  localparam int         PAYLOAD_BYTES     = 13;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         BIT_TIMER_W       = 7;
  localparam int         BIT_IDX_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_SEND = 2'd2,
    ST_NEXT = 2'd3
  } state_e;

  // Packet byte idx (1..13) of the payload, zero-extended to 104 bits and sent MSB first.
  function automatic logic [7:0] payload_byte(input logic [PAYLOAD_W-1:0] p,
                                              input logic [3:0]           idx);
    logic [8*PAYLOAD_BYTES-1:0] padded;
    logic [8*PAYLOAD_BYTES-1:0] shifted;
    padded  = {2'b00, p};
    shifted = '0;
    if (idx >= 4'd1 && idx <= 4'(PAYLOAD_BYTES)) begin
      shifted = padded >> (8 * (PAYLOAD_BYTES - int'(idx)));
    end
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/iteration_uart_packer_uart_tx_byte.sv
// 8N1 byte serialiser: start bit, eight data bits LSB first, stop bit, CLKS_PER_BIT cycles each.
// Latency: start bit drives the line the cycle after a load is accepted.
// Backpressure: load_rdy is high when idle or in the final stop-bit cycle, so bytes chain gap-free.
module uart_tx_byte
  import iteration_uart_packer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 72
) (
  input  logic       clk_72MHz,
  input  logic       rst_n,
  input  logic       load_vld,
  input  logic [7:0] load_dat,
  output logic       load_rdy,
  output logic       stop_end_vld,
  output logic       tx
);

  localparam logic [BIT_TIMER_W-1:0] TIMER_LAST   = BIT_TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_TIMER_W-1:0] TIMER_PENULT = BIT_TIMER_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_IDX_W-1:0]   BIT_DATA_END = 4'd8;
  localparam logic [BIT_IDX_W-1:0]   BIT_STOP     = 4'd9;

  logic                   active_q, active_d;
  logic [BIT_TIMER_W-1:0] timer_q, timer_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   bit_end;

  assign bit_end  = (timer_q == TIMER_LAST);
  assign load_rdy = !active_q || ((bit_idx_q == BIT_STOP) && bit_end);
  // Warns the sequencer one cycle ahead so the next load lands on the final stop cycle.
  assign stop_end_vld = active_q && (bit_idx_q == BIT_STOP) && (timer_q == TIMER_PENULT);
  assign tx = tx_q;

  // Bit timing and shifting: line value for the next bit is registered as the current one ends.
  always_comb begin
    active_d  = active_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    if (load_vld && load_rdy) begin
      active_d  = 1'b1;
      timer_d   = '0;
      bit_idx_d = '0;
      shift_d   = load_dat;
      tx_d      = 1'b0;
    end else if (active_q) begin
      if (bit_end) begin
        timer_d = '0;
        if (bit_idx_q == BIT_STOP) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q < BIT_DATA_END) begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end else begin
            tx_d = 1'b1;
          end
        end
      end else begin
        timer_d = timer_q + 7'd1;
      end
    end
  end

  // Register shifter state; reset returns the line to idle-high immediately.
  always_ff @(posedge clk_72MHz) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      active_q  <= active_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: rtl/iteration_uart_packer.sv
// Latches a 102-bit iteration word, acks the parser, sends SYNC + 13 payload bytes (+ XOR byte with PACKET_CHECKSUM_EN) as UART 8N1.
// Latency: first start bit the cycle after ACK sees sensor_data_avl low; packet lasts 10*CLKS_PER_BIT*(14|15) cycles.
// Backpressure: requests arriving while busy are left unacknowledged and taken in the first IDLE cycle after busy falls.
module iteration_uart_packer
  import iteration_uart_packer_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 72,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic                 clk_72MHz,
  input  logic                 rst_n,
  input  logic [PAYLOAD_W-1:0] sensor_iterations,
  input  logic                 sensor_data_avl,
  output logic                 reset_parser,
  output logic                 uart_tx,
  output logic                 busy,
  output logic [15:0]          packets_sent
);

`ifdef PACKET_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd14;
`else
  localparam logic [3:0] LAST_IDX = 4'd13;
`endif

  state_e               state_q, state_d;
  logic                 reset_parser_q, reset_parser_d;
  logic                 busy_q, busy_d;
  logic [3:0]           byte_idx_q, byte_idx_d;
  logic [PAYLOAD_W-1:0] shadow_q, shadow_d;
  logic [15:0]          packets_sent_q, packets_sent_d;

  logic                 load_vld;
  logic [3:0]           load_idx;
  logic [7:0]           load_dat;
  logic                 tx_load_rdy;
  logic                 tx_stop_end;

  assign reset_parser = reset_parser_q;
  assign busy         = busy_q;
  assign packets_sent = packets_sent_q;

  // Sequencer: accept, wait for the parser to drop avl, then walk the packet byte by byte.
  always_comb begin
    state_d        = state_q;
    reset_parser_d = reset_parser_q;
    busy_d         = busy_q;
    byte_idx_d     = byte_idx_q;
    shadow_d       = shadow_q;
    packets_sent_d = packets_sent_q;
    load_vld       = 1'b0;
    load_idx       = 4'd0;
    case (state_q)
      ST_IDLE: begin
        if (sensor_data_avl) begin
          shadow_d       = sensor_iterations;
          reset_parser_d = 1'b1;
          busy_d         = 1'b1;
          state_d        = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!sensor_data_avl && tx_load_rdy) begin
          reset_parser_d = 1'b0;
          byte_idx_d     = 4'd0;
          load_vld       = 1'b1;
          load_idx       = 4'd0;
          state_d        = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_stop_end) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (byte_idx_q == LAST_IDX) begin
          packets_sent_d = packets_sent_q + 16'd1;
          busy_d         = 1'b0;
          state_d        = ST_IDLE;
        end else if (tx_load_rdy) begin
          byte_idx_d = byte_idx_q + 4'd1;
          load_vld   = 1'b1;
          load_idx   = byte_idx_q + 4'd1;
          state_d    = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef PACKET_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  // Fold each payload byte into the running XOR as it enters the shifter; clear on accept.
  always_comb begin
    csum_d = csum_q;
    if (state_q == ST_IDLE && sensor_data_avl) begin
      csum_d = 8'h00;
    end else if (load_vld && tx_load_rdy && load_idx != 4'd0 && load_idx != LAST_IDX) begin
      csum_d = csum_q ^ load_dat;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge clk_72MHz) begin
    if (!rst_n) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  // Byte mux: sync byte first, then payload MSB first, then the checksum when present.
  always_comb begin
    load_dat = payload_byte(shadow_q, load_idx);
    if (load_idx == 4'd0) begin
      load_dat = SYNC_BYTE;
    end
`ifdef PACKET_CHECKSUM_EN
    else if (load_idx == LAST_IDX) begin
      load_dat = csum_q;
    end
`endif
  end

  // FSM state and registered outputs; reset aborts any packet in flight.
  always_ff @(posedge clk_72MHz) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      reset_parser_q <= 1'b0;
      busy_q         <= 1'b0;
      byte_idx_q     <= 4'd0;
      shadow_q       <= '0;
      packets_sent_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      reset_parser_q <= reset_parser_d;
      busy_q         <= busy_d;
      byte_idx_q     <= byte_idx_d;
      shadow_q       <= shadow_d;
      packets_sent_q <= packets_sent_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk_72MHz   (clk_72MHz),
    .rst_n       (rst_n),
    .load_vld    (load_vld),
    .load_dat    (load_dat),
    .load_rdy    (tx_load_rdy),
    .stop_end_vld(tx_stop_end),
    .tx          (uart_tx)
  );

endmodule

// File: tb/tb_iteration_uart_packer.sv
// Bench for iteration_uart_packer: parser handshake model, UART receiver, byte-level packet model.
// Latency: checks ack, first start bit and packet duration against cycle-exact expectations.
// Backpressure: checks a request raised while busy is only acknowledged after busy falls.
module tb_iteration_uart_packer;

  localparam int CPB      = 4;
  localparam int BYTE_CYC = 10 * CPB;
`ifdef PACKET_CHECKSUM_EN
  localparam int NBYTES = 15;
`else
  localparam int NBYTES = 14;
`endif

  logic         clk_72MHz = 1'b0;
  logic         rst_n = 1'b0;
  logic [101:0] sensor_iterations = '0;
  logic         sensor_data_avl = 1'b0;
  logic         reset_parser;
  logic         uart_tx;
  logic         busy;
  logic [15:0]  packets_sent;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_pkts = 0;

  logic [7:0] rx_dat[$];
  bit         rx_ok[$];
  int         rx_cyc[$];
  logic [7:0] exp_q[$];

  iteration_uart_packer #(.CLKS_PER_BIT(CPB)) dut (
    .clk_72MHz        (clk_72MHz),
    .rst_n            (rst_n),
    .sensor_iterations(sensor_iterations),
    .sensor_data_avl  (sensor_data_avl),
    .reset_parser     (reset_parser),
    .uart_tx          (uart_tx),
    .busy             (busy),
    .packets_sent     (packets_sent)
  );

  always #5 clk_72MHz = ~clk_72MHz;
  always @(posedge clk_72MHz) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART receiver: samples mid-bit on negedges, records byte, framing and start cycle.
  initial begin : rx_mon
    logic [7:0] b;
    bit ok;
    int sc;
    forever begin
      @(negedge clk_72MHz);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        sc = cyc;
        ok = 1'b1;
        b  = 8'h00;
        repeat (CPB / 2) @(negedge clk_72MHz);
        if (uart_tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk_72MHz);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk_72MHz);
        if (uart_tx !== 1'b1) ok = 1'b0;
        rx_dat.push_back(b);
        rx_ok.push_back(ok);
        rx_cyc.push_back(sc);
      end
    end
  end

  task automatic rx_clear();
    rx_dat.delete();
    rx_ok.delete();
    rx_cyc.delete();
  endtask

  // Packet model: peel payload bytes off the LSB end, prepend sync, append XOR if enabled.
  task automatic build_exp(input logic [101:0] p);
    logic [103:0] pad;
`ifdef PACKET_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    pad = {2'b00, p};
    exp_q.delete();
    for (int i = 0; i < 13; i++) begin
      exp_q.push_front(pad[7:0]);
`ifdef PACKET_CHECKSUM_EN
      x = x ^ pad[7:0];
`endif
      pad = pad >> 8;
    end
    exp_q.push_front(8'hA5);
`ifdef PACKET_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic raise_req(input logic [101:0] p, output int raise_c);
    @(posedge clk_72MHz);
    #1;
    sensor_iterations = p;
    sensor_data_avl   = 1'b1;
    raise_c           = cyc;
  endtask

  // Parser side: wait for ack, keep avl up for `hold` more cycles, then drop it.
  task automatic ack_and_drop(input int hold, output int ack_c, output int drop_c);
    int waited;
    int bad;
    waited = 0;
    bad    = 0;
    while (reset_parser !== 1'b1 && waited < 3000) begin
      @(negedge clk_72MHz);
      waited++;
    end
    ack_c = cyc;
    chk("ack_rise", 32'(reset_parser), 1);
    chk("busy_at_ack", 32'(busy), 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_72MHz);
      if (reset_parser !== 1'b1) bad++;
    end
    @(posedge clk_72MHz);
    #1;
    sensor_data_avl = 1'b0;
    drop_c = cyc;
    @(negedge clk_72MHz);
    if (reset_parser !== 1'b1) bad++;
    chk("ack_held_until_avl_low", bad, 0);
    @(negedge clk_72MHz);
    chk("ack_release", 32'(reset_parser), 0);
  endtask

  task automatic wait_idle(output int fall_c);
    int waited;
    waited = 0;
    @(negedge clk_72MHz);
    while (busy !== 1'b0 && waited < 3000) begin
      @(negedge clk_72MHz);
      waited++;
    end
    fall_c = cyc;
    chk("busy_fall", 32'(busy), 0);
  endtask

  task automatic check_packet(input string tag, input int base, input int drop_c);
    int gap_bad;
    int frm_bad;
    gap_bad = 0;
    frm_bad = 0;
    for (int k = 0; k < NBYTES; k++) begin
      if (base + k < rx_dat.size()) begin
        chk($sformatf("%s_byte%0d", tag, k), 32'(rx_dat[base + k]), 32'(exp_q[k]));
        if (!rx_ok[base + k]) frm_bad++;
        if (k > 0 && (rx_cyc[base + k] - rx_cyc[base + k - 1]) != BYTE_CYC) gap_bad++;
      end
    end
    if (base < rx_cyc.size()) chk({tag, "_first_start"}, rx_cyc[base], drop_c + 1);
    chk({tag, "_framing"}, frm_bad, 0);
    chk({tag, "_byte_gap"}, gap_bad, 0);
  endtask

  task automatic run_packet(input string tag, input logic [101:0] p, input int hold);
    int raise_c, ack_c, drop_c, fall_c;
    rx_clear();
    build_exp(p);
    raise_req(p, raise_c);
    ack_and_drop(hold, ack_c, drop_c);
    chk({tag, "_ack_latency"}, ack_c, raise_c + 1);
    wait_idle(fall_c);
    exp_pkts++;
    chk({tag, "_duration"}, fall_c, drop_c + 1 + BYTE_CYC * NBYTES);
    chk({tag, "_count"}, 32'(packets_sent), exp_pkts & 32'hFFFF);
    repeat (60) @(negedge clk_72MHz);
    chk({tag, "_rx_len"}, rx_dat.size(), NBYTES);
    check_packet(tag, 0, drop_c);
  endtask

  function automatic logic [101:0] rand_payload();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[101:0];
  endfunction

  initial begin : main
    logic [101:0] pa, pb;
    int rc, ac, dropa, dropb, fa, fb, early, w;

    // Power-on reset values.
    repeat (3) @(posedge clk_72MHz);
    @(negedge clk_72MHz);
    chk("rst_uart_tx", 32'(uart_tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(reset_parser), 0);
    chk("rst_count", 32'(packets_sent), 0);
    @(posedge clk_72MHz);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk_72MHz);

    // Directed payload from the block description, ack dropped after 3 cycles.
    run_packet("dir", 102'h2_AAAA_5555_0F0F_F0F0_1234_5678, 3);

    // Reset mid-packet aborts and clears the counter.
    raise_req(rand_payload(), rc);
    ack_and_drop(0, ac, dropa);
    repeat (100) @(posedge clk_72MHz);
    @(negedge clk_72MHz);
    chk("pre_reset_busy", 32'(busy), 1);
    @(posedge clk_72MHz);
    #1;
    rst_n = 1'b0;
    @(posedge clk_72MHz);
    @(negedge clk_72MHz);
    chk("midrst_uart_tx", 32'(uart_tx), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ack", 32'(reset_parser), 0);
    chk("midrst_count", 32'(packets_sent), 0);
    @(posedge clk_72MHz);
    #1;
    rst_n = 1'b1;
    exp_pkts = 0;
    repeat (60) @(posedge clk_72MHz);

    // Second request raised while busy: no early ack, taken right after busy falls.
    rx_clear();
    pa = rand_payload();
    pb = rand_payload();
    raise_req(pa, rc);
    ack_and_drop(0, ac, dropa);
    repeat (50) @(posedge clk_72MHz);
    raise_req(pb, rc);
    early = 0;
    w = 0;
    @(negedge clk_72MHz);
    while (busy !== 1'b0 && w < 3000) begin
      if (reset_parser !== 1'b0) early++;
      @(negedge clk_72MHz);
      w++;
    end
    fa = cyc;
    chk("bp_no_early_ack", early, 0);
    chk("bp_a_duration", fa, dropa + 1 + BYTE_CYC * NBYTES);
    exp_pkts++;
    ack_and_drop(2, ac, dropb);
    chk("bp_ack_after_busy", ac, fa + 1);
    wait_idle(fb);
    exp_pkts++;
    chk("bp_b_duration", fb, dropb + 1 + BYTE_CYC * NBYTES);
    chk("bp_count", 32'(packets_sent), exp_pkts);
    repeat (60) @(negedge clk_72MHz);
    chk("bp_rx_len", rx_dat.size(), 2 * NBYTES);
    build_exp(pa);
    check_packet("bp_a", 0, dropa);
    build_exp(pb);
    check_packet("bp_b", NBYTES, dropb);

    // Randomized payloads and ack hold times.
    for (int n = 0; n < 3; n++) begin
      run_packet($sformatf("rnd%0d", n), rand_payload(), int'($urandom_range(0, 4)));
    end

    // Counter wrap from 16'hFFFF.
    @(posedge clk_72MHz);
    #1;
    force dut.packets_sent_q = 16'hFFFF;
    @(posedge clk_72MHz);
    #1;
    release dut.packets_sent_q;
    @(negedge clk_72MHz);
    chk("preload_count", 32'(packets_sent), 32'hFFFF);
    exp_pkts = 32'hFFFF;
    run_packet("wrap", rand_payload(), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
